// File: rtl/gpio_bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// gpio_bus_arb_pkg
// Shared definitions for the two-master GPIO local-bus arbiter.
//   CORE_XLEN   : core data width (default for the arbiter XLEN parameter)
//   CORE_AWIDTH : GPIO local-bus address width (default for AWIDTH)
//   BE_W        : number of byte write enables on every bus port
//   pick_m1()   : round-robin owner choice between the two masters
// ---------------------------------------------------------------------------
package gpio_bus_arb_pkg;

   localparam int CORE_XLEN   = 32;
   localparam int CORE_AWIDTH = 12;
   localparam int BE_W        = 4;

   // Returns 1 when master 1 wins the bus.
   // A lone requester always wins. On a tie the master that was not served
   // last wins; last_m1 = 1 therefore favours master 0.
   function automatic logic pick_m1(input logic r0,
                                    input logic r1,
                                    input logic last_m1);
      logic win;
      if (r0 && r1) begin
         win = !last_m1;
      end else begin
         win = r1;
      end
      return win;
   endfunction

endpackage

// File: rtl/gpio_bus_arb.sv
// ---------------------------------------------------------------------------
// gpio_bus_arb
// Arbitrates the CPU (m0) and debug (m1) masters onto the single-slave GPIO
// local bus. One transaction at a time: grant, one bus cycle, response.
//
// Ports
//   clk, rst_n                 : clock, synchronous active-low reset
//   m0_req / m1_req            : access request, sampled only while idle
//   m0_addr / m1_addr          : request address (AWIDTH)
//   m0_we / m1_we              : byte write enables, 4'b0000 = read
//   m0_wdata / m1_wdata        : write data (XLEN)
//   m0_gnt / m1_gnt            : one-cycle pulse, request captured
//   m0_rvalid / m1_rvalid      : one-cycle pulse, transaction complete
//   m0_rdata / m1_rdata        : read data, valid with rvalid, held otherwise
//   s_sel, s_addr, s_we,
//   s_wdata                    : GPIO local-bus drive (all zero when idle)
//   s_rdata                    : GPIO read data
//   dbg_state                  : current FSM state (IDLE/ACCESS/RESP)
//
// Handshake: a master raises req with addr/we/wdata stable and keeps them
// until it sees its gnt pulse; gnt is the capture point, after which the
// request fields are free to change. Exactly one rvalid pulse follows every
// gnt two cycles later (writes included) unless reset intervenes. A req that
// falls before its gnt starts nothing.
//
// Timing (all outputs registered): gnt in cycle N, s_sel in N+1, rvalid and
// rdata in N+2, next gnt at N+3 at the earliest. The FSM state names the
// phase whose outputs are launched at the end of that state, so ACCESS is the
// cycle that gnt is visible and RESP is the cycle that s_sel is visible.
// s_rdata is sampled on the clock edge that ends the s_sel cycle.
// ---------------------------------------------------------------------------
module gpio_bus_arb
   import gpio_bus_arb_pkg::*;
#(
   parameter int XLEN   = CORE_XLEN,
   parameter int AWIDTH = CORE_AWIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic [AWIDTH-1:0] m0_addr,
   input  logic [AWIDTH-1:0] m1_addr,
   input  logic [BE_W-1:0]   m0_we,
   input  logic [BE_W-1:0]   m1_we,
   input  logic [XLEN-1:0]   m0_wdata,
   input  logic [XLEN-1:0]   m1_wdata,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   output logic [XLEN-1:0]   m0_rdata,
   output logic [XLEN-1:0]   m1_rdata,
   output logic              s_sel,
   output logic [AWIDTH-1:0] s_addr,
   output logic [BE_W-1:0]   s_we,
   output logic [XLEN-1:0]   s_wdata,
   input  logic [XLEN-1:0]   s_rdata,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ACCESS = ST_ACCESS,
      RESP   = ST_RESP
   } state_t;

   state_t              state, state_nx;
   logic                last_m1, last_m1_nx;     // 1: m1 served last
   logic                owner_m1, owner_m1_nx;   // owner of the open transaction
   logic [AWIDTH-1:0]   cap_addr, cap_addr_nx;
   logic [BE_W-1:0]     cap_we, cap_we_nx;
   logic [XLEN-1:0]     cap_wdata, cap_wdata_nx;

   logic                m0_gnt_nx, m1_gnt_nx;
   logic                m0_rvalid_nx, m1_rvalid_nx;
   logic [XLEN-1:0]     m0_rdata_nx, m1_rdata_nx;
   logic                s_sel_nx;
   logic [AWIDTH-1:0]   s_addr_nx;
   logic [BE_W-1:0]     s_we_nx;
   logic [XLEN-1:0]     s_wdata_nx;
   logic                win_m1;

   assign dbg_state = state;

   always_comb begin
      state_nx     = state;
      last_m1_nx   = last_m1;
      owner_m1_nx  = owner_m1;
      cap_addr_nx  = cap_addr;
      cap_we_nx    = cap_we;
      cap_wdata_nx = cap_wdata;
      m0_gnt_nx    = 1'b0;
      m1_gnt_nx    = 1'b0;
      m0_rvalid_nx = 1'b0;
      m1_rvalid_nx = 1'b0;
      m0_rdata_nx  = m0_rdata;
      m1_rdata_nx  = m1_rdata;
      s_sel_nx     = 1'b0;
      s_addr_nx    = '0;
      s_we_nx      = '0;
      s_wdata_nx   = '0;
      win_m1       = pick_m1(m0_req, m1_req, last_m1);

      case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               owner_m1_nx = win_m1;
               if (win_m1) begin
                  cap_addr_nx  = m1_addr;
                  cap_we_nx    = m1_we;
                  cap_wdata_nx = m1_wdata;
                  m1_gnt_nx    = 1'b1;
               end else begin
                  cap_addr_nx  = m0_addr;
                  cap_we_nx    = m0_we;
                  cap_wdata_nx = m0_wdata;
                  m0_gnt_nx    = 1'b1;
               end
               state_nx = ACCESS;
            end
         end
         ACCESS: begin
            s_sel_nx   = 1'b1;
            s_addr_nx  = cap_addr;
            s_we_nx    = cap_we;
            s_wdata_nx = cap_wdata;
            state_nx   = RESP;
         end
         RESP: begin
            // Writes also complete with rvalid; rdata then carries whatever
            // the slave returned, which masters ignore for writes.
            if (owner_m1) begin
               m1_rvalid_nx = 1'b1;
               m1_rdata_nx  = s_rdata;
            end else begin
               m0_rvalid_nx = 1'b1;
               m0_rdata_nx  = s_rdata;
            end
            last_m1_nx = owner_m1;
            state_nx   = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_m1   <= 1'b1;
         owner_m1  <= 1'b0;
         cap_addr  <= '0;
         cap_we    <= '0;
         cap_wdata <= '0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         s_sel     <= 1'b0;
         s_addr    <= '0;
         s_we      <= '0;
         s_wdata   <= '0;
      end else begin
         state     <= state_nx;
         last_m1   <= last_m1_nx;
         owner_m1  <= owner_m1_nx;
         cap_addr  <= cap_addr_nx;
         cap_we    <= cap_we_nx;
         cap_wdata <= cap_wdata_nx;
         m0_gnt    <= m0_gnt_nx;
         m1_gnt    <= m1_gnt_nx;
         m0_rvalid <= m0_rvalid_nx;
         m1_rvalid <= m1_rvalid_nx;
         m0_rdata  <= m0_rdata_nx;
         m1_rdata  <= m1_rdata_nx;
         s_sel     <= s_sel_nx;
         s_addr    <= s_addr_nx;
         s_we      <= s_we_nx;
         s_wdata   <= s_wdata_nx;
      end
   end

endmodule

// File: tb/tb_gpio_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_gpio_bus_arb
// Bench for gpio_bus_arb. The driver issues requests and, using a slot-level
// model (bus free from a given edge, who was served last), schedules the
// expected grant, bus cycle and response in three queues tagged with the
// clock edge at which each must appear. The monitor samples on the falling
// edge, pops and compares, plays the GPIO slave (returns s_rdata for the
// selected cycle, noise otherwise) and tracks the held rdata of each master.
// ---------------------------------------------------------------------------
module tb_gpio_bus_arb;
   import gpio_bus_arb_pkg::*;

   localparam int XL = CORE_XLEN;
   localparam int AW = CORE_AWIDTH;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic          m0_req = 1'b0, m1_req = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [3:0]    m0_we = '0, m1_we = '0;
   logic [XL-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [XL-1:0] m0_rdata, m1_rdata;
   logic          s_sel;
   logic [AW-1:0] s_addr;
   logic [3:0]    s_we;
   logic [XL-1:0] s_wdata;
   logic [XL-1:0] s_rdata = '0;
   logic [1:0]    dbg_state;

   gpio_bus_arb #(.XLEN(XL), .AWIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m1_req(m1_req),
      .m0_addr(m0_addr), .m1_addr(m1_addr),
      .m0_we(m0_we), .m1_we(m1_we),
      .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
      .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .s_sel(s_sel), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .dbg_state(dbg_state)
   );

   // ---------------- edge bookkeeping ----------------
   int unsigned edge_cnt = 0;   // number of rising edges so far
   logic        rst_seen = 1'b0; // reset was applied at the latest edge
   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      rst_seen <= !rst_n;
   end

   // ---------------- scoreboard ----------------
   typedef struct { int unsigned edge_n; logic m1; } gnt_t;
   typedef struct {
      int unsigned   edge_n;
      logic [AW-1:0] addr;
      logic [3:0]    we;
      logic [XL-1:0] wdata;
      logic [XL-1:0] rdata;
   } bus_t;
   typedef struct { int unsigned edge_n; logic m1; logic [XL-1:0] rdata; } resp_t;

   gnt_t  gnt_q[$];
   bus_t  bus_q[$];
   resp_t resp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
      end
   endtask

   // ---------------- monitor / GPIO slave ----------------
   initial begin : monitor
      gnt_t          g;
      bus_t          b;
      resp_t         r;
      logic [XL-1:0] exp_rd0, exp_rd1;
      exp_rd0 = '0;
      exp_rd1 = '0;
      forever begin
         @(negedge clk);
         if (rst_seen) begin
            // Reset at the last edge cancels anything in flight.
            gnt_q.delete();
            bus_q.delete();
            resp_q.delete();
            exp_rd0 = '0;
            exp_rd1 = '0;
            chk("reset_state", 64'(dbg_state), 64'd0);
         end

         if (gnt_q.size() > 0 && gnt_q[0].edge_n == edge_cnt) begin
            g = gnt_q.pop_front();
            chk("gnt", 64'({m1_gnt, m0_gnt}), g.m1 ? 64'd2 : 64'd1);
         end else begin
            chk("gnt_quiet", 64'({m1_gnt, m0_gnt}), 64'd0);
         end

         if (bus_q.size() > 0 && bus_q[0].edge_n == edge_cnt) begin
            b = bus_q.pop_front();
            chk("s_sel", 64'(s_sel), 64'd1);
            chk("s_addr", 64'(s_addr), 64'(b.addr));
            chk("s_we", 64'(s_we), 64'(b.we));
            chk("s_wdata", 64'(s_wdata), 64'(b.wdata));
            s_rdata = b.rdata;
         end else begin
            chk("s_sel_quiet", 64'(s_sel), 64'd0);
            chk("s_bus_quiet", 64'({s_addr, s_we, s_wdata}), 64'd0);
            s_rdata = XL'($urandom);
         end

         if (resp_q.size() > 0 && resp_q[0].edge_n == edge_cnt) begin
            r = resp_q.pop_front();
            chk("rvalid", 64'({m1_rvalid, m0_rvalid}), r.m1 ? 64'd2 : 64'd1);
            if (r.m1) exp_rd1 = r.rdata;
            else      exp_rd0 = r.rdata;
         end else begin
            chk("rvalid_quiet", 64'({m1_rvalid, m0_rvalid}), 64'd0);
         end

         chk("m0_rdata", 64'(m0_rdata), 64'(exp_rd0));
         chk("m1_rdata", 64'(m1_rdata), 64'(exp_rd1));
      end
   end

   // ---------------- reference model state (driver side) ----------------
   int unsigned free_edge   = 0;  // earliest edge at which a grant may occur
   int          served_last = 1;  // master served most recently; 1 favours m0

   // One cycle of stimulus for the next rising edge.
   task automatic drive(input logic r0, input logic r1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [3:0] w0, input logic [3:0] w1,
                        input logic [XL-1:0] d0, input logic [XL-1:0] d1,
                        input logic [XL-1:0] rd);
      int unsigned e;
      int          win;
      @(negedge clk);
      #1;
      e = edge_cnt + 1;
      rst_n = 1'b1;
      m0_req = r0; m1_req = r1;
      m0_addr = a0; m1_addr = a1;
      m0_we = w0; m1_we = w1;
      m0_wdata = d0; m1_wdata = d1;
      if (e >= free_edge && (r0 || r1)) begin
         if (r0 && r1) win = 1 - served_last;
         else          win = r1 ? 1 : 0;
         gnt_q.push_back('{edge_n: e, m1: (win == 1)});
         if (win == 1)
            bus_q.push_back('{edge_n: e + 1, addr: a1, we: w1, wdata: d1, rdata: rd});
         else
            bus_q.push_back('{edge_n: e + 1, addr: a0, we: w0, wdata: d0, rdata: rd});
         resp_q.push_back('{edge_n: e + 2, m1: (win == 1), rdata: rd});
         served_last = win;
         free_edge   = e + 3;
      end
   endtask

   task automatic drive_rand(input logic r0, input logic r1);
      drive(r0, r1, AW'($urandom), AW'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            XL'($urandom), XL'($urandom), XL'($urandom));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_rand(1'b0, 1'b0);
   endtask

   task automatic apply_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         rst_n  = 1'b0;
         m0_req = 1'b0;
         m1_req = 1'b0;
      end
      served_last = 1;
      free_edge   = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : driver
      apply_reset(2);

      // m0 single read at 0x04
      drive(1'b1, 1'b0, AW'(12'h004), '0, 4'h0, 4'h0, '0, '0, 32'h0000_1ABC);
      idle(4);

      // m1 full-word write; m0 rdata must stay at 0x1ABC
      drive(1'b0, 1'b1, '0, AW'(12'h010), 4'h0, 4'hF, '0, 32'h0000_00A5, XL'($urandom));
      idle(4);

      // both requesting from reset: m0, m1, m0, m1 ...
      apply_reset(1);
      for (int i = 0; i < 12; i++) drive_rand(1'b1, 1'b1);
      idle(3);

      // m0 alone, continuously
      for (int i = 0; i < 12; i++) drive_rand(1'b1, 1'b0);
      idle(3);

      // m1 pulses only while the m0 transaction is in flight
      drive_rand(1'b1, 1'b0);
      drive_rand(1'b0, 1'b1);
      drive_rand(1'b0, 1'b1);
      idle(4);

      // reset in the cycle after the grant, then an immediate new request
      drive_rand(1'b1, 1'b0);
      apply_reset(1);
      drive_rand(1'b0, 1'b1);
      idle(4);

      // reset during the bus cycle suppresses rvalid
      drive_rand(1'b0, 1'b1);
      idle(1);
      apply_reset(1);
      idle(3);

      // randomized traffic with rare resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) apply_reset(1);
         else drive_rand($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      end
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
